// File: rtl/usb_tx_pkt_gen.sv
`default_nettype none
// =============================================================================
// Module   : usb_tx_pkt_gen
// Purpose  : USB 2.0 transmit packet generator (token, SOF, handshake, data)
//            emitting a flagged byte stream toward the PHY-side serializer.
// Revision : 1.0 - initial release
// =============================================================================
module usb_tx_pkt_gen #(
    parameter  int MAX_PAYLOAD = 64,
    parameter  bit EN_SOF      = 1'b1,
    parameter  bit EN_DATA     = 1'b1,
    localparam int LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [1:0]       tx_type,
    input  logic [3:0]       tx_pid,
    input  logic [6:0]       tx_addr,
    input  logic [3:0]       tx_endp,
    input  logic [10:0]      tx_frame,
    input  logic [LEN_W-1:0] tx_len,
    input  logic [7:0]       pl_data,
    input  logic             pl_valid,
    output logic             pl_ready,
    output logic [7:0]       tx_to_data,
    output logic             tx_to_valid,
    output logic             tx_to_sop,
    output logic             tx_to_eop,
    input  logic             tx_to_ready,
    output logic [3:0]       tx_con_pid,
    output logic             tx_con_pid_en,
    output logic             tx_err
);

    localparam logic [1:0]       c_type_token = 2'd0;
    localparam logic [1:0]       c_type_sof   = 2'd1;
    localparam logic [1:0]       c_type_hs    = 2'd2;
    localparam logic [1:0]       c_type_data  = 2'd3;
    localparam logic [LEN_W-1:0] c_max_len    = LEN_W'(MAX_PAYLOAD);
    localparam logic [LEN_W-1:0] c_len_one    = LEN_W'(1);

    // State names the byte that is (or is about to be) held in the output stage.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PID    = 3'd1,
        S_TOK1   = 3'd2,
        S_TOK2   = 3'd3,
        S_DATA   = 3'd4,
        S_CRC_LO = 3'd5,
        S_CRC_HI = 3'd6
    } state_t;

    state_t           r_state;
    logic [3:0]       r_pid;
    logic [10:0]      r_d;
    logic [LEN_W-1:0] r_cnt;
    logic [15:0]      r_crc16;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_sop;
    logic             r_eop;
    logic [3:0]       r_con_pid;
    logic             r_con_pid_en;
    logic             r_err;

    logic             w_load;
    logic             w_done;
    logic             w_reject;

    function automatic logic [4:0] crc5_calc(input logic [10:0] d);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            if (d[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'h05;
            else             c = {c[3:0], 1'b0};
        end
        return ~c;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (b[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign w_load   = !r_valid || tx_to_ready;
    assign w_done   = r_valid && r_eop && tx_to_ready;
    assign w_reject = ((tx_type == c_type_sof)  && !EN_SOF) ||
                      ((tx_type == c_type_data) && (!EN_DATA || (tx_len > c_max_len)));

    assign tx_ready      = (r_state == S_IDLE) && !rst;
    assign pl_ready      = (r_state == S_DATA) && w_load && !rst;
    assign tx_to_data    = r_data;
    assign tx_to_valid   = r_valid;
    assign tx_to_sop     = r_sop;
    assign tx_to_eop     = r_eop;
    assign tx_con_pid    = r_con_pid;
    assign tx_con_pid_en = r_con_pid_en;
    assign tx_err        = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pid        <= 4'h0;
            r_d          <= 11'h000;
            r_cnt        <= '0;
            r_crc16      <= 16'hFFFF;
            r_data       <= 8'h00;
            r_valid      <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_con_pid    <= 4'h0;
            r_con_pid_en <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_con_pid_en <= 1'b0;
            r_err        <= 1'b0;
            if (w_done) begin
                r_valid      <= 1'b0;
                r_sop        <= 1'b0;
                r_eop        <= 1'b0;
                r_con_pid    <= r_pid;
                r_con_pid_en <= 1'b1;
                r_state      <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (tx_valid) begin
                            if (w_reject) begin
                                r_err <= 1'b1;
                            end else begin
                                r_pid   <= tx_pid;
                                r_d     <= (tx_type == c_type_token) ? {tx_endp, tx_addr} : tx_frame;
                                r_cnt   <= tx_len;
                                r_crc16 <= 16'hFFFF;
                                r_data  <= {~tx_pid, tx_pid};
                                r_valid <= 1'b1;
                                r_sop   <= 1'b1;
                                r_eop   <= (tx_type == c_type_hs);
                                if (tx_type == c_type_hs)
                                    r_state <= S_PID;
                                else if (tx_type == c_type_data)
                                    r_state <= (tx_len == '0) ? S_CRC_LO : S_DATA;
                                else
                                    r_state <= S_TOK1;
                            end
                        end
                    end
                    S_PID: begin
                        // Handshake byte in flight; only completion leaves here.
                    end
                    S_TOK1: begin
                        if (w_load) begin
                            r_data  <= r_d[7:0];
                            r_valid <= 1'b1;
                            r_sop   <= 1'b0;
                            r_state <= S_TOK2;
                        end
                    end
                    S_TOK2: begin
                        if (w_load) begin
                            r_data  <= {crc5_calc(r_d), r_d[10:8]};
                            r_valid <= 1'b1;
                            r_sop   <= 1'b0;
                            r_eop   <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (w_load) begin
                            r_sop <= 1'b0;
                            if (pl_valid) begin
                                r_data  <= pl_data;
                                r_valid <= 1'b1;
                                r_crc16 <= crc16_byte(r_crc16, pl_data);
                                r_cnt   <= r_cnt - c_len_one;
                                if (r_cnt == c_len_one)
                                    r_state <= S_CRC_LO;
                            end else begin
                                r_valid <= 1'b0;
                            end
                        end
                    end
                    S_CRC_LO: begin
                        if (w_load) begin
                            r_data  <= ~r_crc16[7:0];
                            r_valid <= 1'b1;
                            r_sop   <= 1'b0;
                            r_state <= S_CRC_HI;
                        end
                    end
                    S_CRC_HI: begin
                        if (w_load) begin
                            r_data  <= ~r_crc16[15:8];
                            r_valid <= 1'b1;
                            r_sop   <= 1'b0;
                            r_eop   <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
